instruction_fetch_unit: RTL and testbench

- IF stage of the separated pipeline. Owns the PC and drives the byte address into the instruction memory.
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Honours stall and flush from the hazard unit and branch redirects from EX.
- The instruction memory is the responder; this block is its only initiator. Memory read is combinational (zero-latency).

---
 rtl/instruction_fetch_unit_pkg.sv | 22 ++
 rtl/instruction_fetch_unit_pc_register.sv | 45 ++++
 rtl/instruction_fetch_unit.sv | 67 ++++++
 tb/tb_instruction_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID consumer.
package instruction_fetch_unit_pkg;

    localparam int ADDR_WIDTH  = 8;
    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    // IF/ID pipeline register contents, also consumed by the decode stage.
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc_plus4;
        logic                   valid;
    } ifid_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~ADDR_WIDTH'(PC_STEP - 1);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter with reset/branch/stall/increment priority selection.
module pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Sequential increment wraps naturally at the top of the address space.
    assign pc_inc = pc_q + ADDR_WIDTH'(PC_STEP);

    // Next PC: a redirect beats a stall, otherwise hold or step forward.
    always_comb begin
        pc_d = pc_inc;
        if (branch_taken_i) begin
            pc_d = word_align(branch_target_i);
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // PC register, reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_inc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 8'h00,
    parameter int                    CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [ADDR_WIDTH-1:0]  imem_address,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [INSTR_WIDTH-1:0] ifid_instruction,
    output logic [ADDR_WIDTH-1:0]  ifid_pc_plus4,
    output logic                   ifid_valid,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    logic [ADDR_WIDTH-1:0] pc_plus4;
    ifid_t                 ifid_q;
    logic [CNT_WIDTH-1:0]  count_q;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .pc_o            (pc),
        .pc_plus4_o      (pc_plus4)
    );

    // Memory is zero-latency, so the current PC addresses it directly.
    assign imem_address = pc;

    // IF/ID register: redirect or flush inserts a bubble, stall freezes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else if (branch_taken || flush) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else if (!stall) begin
            ifid_q <= '{instr: imem_instruction, pc_plus4: pc_plus4, valid: 1'b1};
        end
    end

    // Saturating count of instructions actually accepted into IF/ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (!branch_taken && !flush && !stall && (count_q != '1)) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign ifid_instruction = ifid_q.instr;
    assign ifid_pc_plus4    = ifid_q.pc_plus4;
    assign ifid_valid       = ifid_q.valid;
    assign fetch_count      = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for the fetch stage against a cycle-level reference model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_address;
    logic [31:0] imem_instruction;
    logic [7:0]  pc;
    logic [31:0] ifid_instruction;
    logic [7:0]  ifid_pc_plus4;
    logic        ifid_valid;
    logic [15:0] fetch_count;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [7:0]  pc4;
        logic        valid;
        logic [15:0] count;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] mem[64];

    int mPc;
    int mInstr;
    int mPc4;
    int mValid;
    int mCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory responder: combinational word read.
    assign imem_instruction = mem[imem_address[7:2]];

    instruction_fetch_unit #(
        .RESET_PC  (8'h00),
        .CNT_WIDTH (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .pc               (pc),
        .ifid_instruction (ifid_instruction),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid),
        .fetch_count      (fetch_count)
    );

    // Reference model step: what one rising edge should do, then queue it.
    task automatic modelEdge(input bit r, input bit s, input bit f, input bit b, input int t);
        int   fetched;
        int   nextPc;
        exp_t e;
        fetched = int'(mem[mPc / 4]);
        if (r) begin
            nextPc = 0;
            mInstr = 0; mPc4 = 0; mValid = 0; mCount = 0;
        end else begin
            if (b)      nextPc = (t / 4) * 4;
            else if (s) nextPc = mPc;
            else        nextPc = (mPc + 4) % 256;
            if (b || f) begin
                mInstr = 0; mPc4 = 0; mValid = 0;
            end else if (!s) begin
                mInstr = fetched;
                mPc4   = (mPc + 4) % 256;
                mValid = 1;
                if (mCount < 65535) mCount = mCount + 1;
            end
        end
        mPc = nextPc;
        e.pc    = 8'(mPc);
        e.instr = 32'(mInstr);
        e.pc4   = 8'(mPc4);
        e.valid = 1'(mValid);
        e.count = 16'(mCount);
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs away from the edge, then record the expectation.
    task automatic applyStimulus(input bit r, input bit s, input bit f, input bit b, input int t);
        @(negedge clk);
        reset = r; stall = s; flush = f; branch_taken = b; branch_target = 8'(t);
        @(posedge clk);
        modelEdge(r, s, f, b, t);
    endtask

    task automatic compareField(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("pc", int'(pc), int'(e.pc));
        compareField("imem_address", int'(imem_address), int'(e.pc));
        compareField("ifid_instruction", int'(ifid_instruction), int'(e.instr));
        compareField("ifid_pc_plus4", int'(ifid_pc_plus4), int'(e.pc4));
        compareField("ifid_valid", int'(ifid_valid), int'(e.valid));
        compareField("fetch_count", int'(fetch_count), int'(e.count));
    endtask

    // Monitor: after every edge, compare the DUT against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        mPc = 0; mInstr = 0; mPc4 = 0; mValid = 0; mCount = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'hE3A01005;
        mem[1] = 32'hE2811001;
        $display("[TB] starting fetch unit bench");

        // Reset then free run.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);

        // Stall three cycles at pc 0x08, then release.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Branch to a misaligned target while stalled.
        applyStimulus(0, 1, 0, 1, 8'h23);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Flush together with stall at pc 0x10.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Flush together with branch, then wrap past the top of memory.
        applyStimulus(0, 0, 1, 1, 8'h80);
        applyStimulus(0, 0, 0, 1, 8'hFC);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

        // Reset on the same edge as a branch.
        applyStimulus(1, 0, 0, 1, 8'h40);
        applyStimulus(0, 0, 0, 0, 0);

        // Randomized mix of hazards and redirects.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 25,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 10,
                          int'($urandom_range(0, 255)));
        end

        // Long free run to drive the fetch counter into saturation.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        compareField("scoreboard_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
